// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-timing helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} rx_state_t;
  function automatic int mid_of(input int oversample);
    return oversample / 2;
  endfunction
endpackage

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: 3-sample window with majority vote on the RX line
module uart_rx_bit_sampler (
  input  logic UCLK,
  input  logic reset,
  input  logic i_capture,
  input  logic i_rx,
  output logic o_vote
);
  logic [1:0] r_smp;
  // Shift in the line on each capture tick; the third sample is the live line
  always_ff @(posedge UCLK or negedge reset)
    if (!reset) r_smp <= '0;
    else if (i_capture) r_smp <= {r_smp[0], i_rx};
  assign o_vote = (r_smp[1] & r_smp[0]) | (r_smp[1] & i_rx) | (r_smp[0] & i_rx);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive control FSM with oversampled majority-vote bit recovery
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic                          os_tick,
  input  logic                          rx_in,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  output logic                          deserializer_enable,
  output logic [$clog2(DATA_WIDTH)-1:0] data_index,
  output logic                          sampled_bit,
  output logic                          rx_busy,
  output logic                          rx_done,
  output logic                          frame_error,
  output logic                          parity_error
);
  localparam int MID = mid_of(OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] C_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] C_MIDM1 = TW'(MID - 1);
  localparam logic [TW-1:0] C_MIDP1 = TW'(MID + 1);
  localparam logic [IW-1:0] C_DLAST = IW'(DATA_WIDTH - 1);

  rx_state_t     r_state;
  logic [TW-1:0] r_tick;
  logic [IW-1:0] r_idx;
  logic          r_de, r_bit, r_busy, r_done, r_fe, r_perr;
  logic          r_pe, r_po, r_xor, r_perr_nx;
  logic          w_vote, w_cap, w_vote_t, w_wrap;

  assign w_vote_t = r_tick == C_MIDP1;
  assign w_wrap   = r_tick == C_LAST;
  assign w_cap    = os_tick && r_tick >= C_MIDM1 && r_tick <= C_MIDP1;

  uart_rx_bit_sampler u_sampler (
    .UCLK      (UCLK),
    .reset     (reset),
    .i_capture (w_cap),
    .i_rx      (rx_in),
    .o_vote    (w_vote)
  );

  // Frame sequencing: the start-detect tick is tick 0 of the start bit, so the counter
  // leaves IDLE already at 1; everything except the pulses advances only on os_tick
  always_ff @(posedge UCLK or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_idx     <= '0;
      r_de      <= 1'b0;
      r_bit     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fe      <= 1'b0;
      r_perr    <= 1'b0;
      r_pe      <= 1'b0;
      r_po      <= 1'b0;
      r_xor     <= 1'b0;
      r_perr_nx <= 1'b0;
    end else begin
      r_de   <= 1'b0;
      r_done <= 1'b0;
      if (os_tick) begin
        r_tick <= (r_state == IDLE) ? TW'(!rx_in) : w_wrap ? '0 : r_tick + TW'(1);
        case (r_state)
          IDLE:
            if (!rx_in) begin
              r_state <= START;
              r_busy  <= 1'b1;
              r_pe    <= parity_en;
              r_po    <= parity_odd;
              r_xor   <= 1'b0;
            end
          START:
            if (w_vote_t && w_vote) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (w_wrap) r_state <= DATA;
          DATA: begin
            if (w_vote_t) begin
              r_de  <= 1'b1;
              r_bit <= w_vote;
              r_xor <= r_xor ^ w_vote;
            end
            if (w_wrap) begin
              r_idx <= (r_idx == C_DLAST) ? '0 : r_idx + IW'(1);
              if (r_idx == C_DLAST) r_state <= r_pe ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (w_vote_t) r_perr_nx <= r_xor ^ w_vote ^ r_po;
            if (w_wrap) r_state <= STOP;
          end
          STOP:
            if (w_vote_t) begin
              r_done  <= 1'b1;
              r_fe    <= ~w_vote;
              r_perr  <= r_pe & r_perr_nx;
              r_busy  <= ~w_vote;
              r_state <= w_vote ? IDLE : RECOVER;
            end
          RECOVER:
            if (rx_in) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          default: r_state <= IDLE;
        endcase
      end
    end

  assign deserializer_enable = r_de;
  assign data_index          = r_idx;
  assign sampled_bit         = r_bit;
  assign rx_busy             = r_busy;
  assign rx_done             = r_done;
  assign frame_error         = r_fe;
  assign parity_error        = r_perr;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized and directed checks of uart_rx_ctrl against a tick-level frame model
module tb_uart_rx_ctrl;
  localparam int DW  = 8;
  localparam int OS  = 16;
  localparam int MID = OS / 2;

  typedef struct {int t; int a; int b;} ev_t;

  logic UCLK = 1'b0, reset = 1'b0, os_tick = 1'b0, rx_in = 1'b1, parity_en = 1'b0, parity_odd = 1'b0;
  logic de, sb, busy, done, fe, pe;
  logic [2:0] di;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .UCLK                (UCLK),
    .reset               (reset),
    .os_tick             (os_tick),
    .rx_in               (rx_in),
    .parity_en           (parity_en),
    .parity_odd          (parity_odd),
    .deserializer_enable (de),
    .data_index          (di),
    .sampled_bit         (sb),
    .rx_busy             (busy),
    .rx_done             (done),
    .frame_error         (fe),
    .parity_error        (pe)
  );

  always #5 UCLK = ~UCLK;

  int n_cmp = 0, n_bad = 0, tick_id = -1;
  bit L[$], cp_en[$], cp_odd[$];
  bit gb[$], gf[$], gp[$];
  bit eb[], ef[], ep[];
  ev_t got_en[$], got_dn[$], exp_en[$], exp_dn[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge UCLK) begin
    if (de === 1'b1) got_en.push_back('{tick_id, int'(di), int'(sb)});
    if (done === 1'b1) got_dn.push_back('{tick_id, int'(fe), int'(pe)});
  end

  task automatic clear_stim();
    L.delete(); cp_en.delete(); cp_odd.delete();
  endtask

  task automatic idle(input int n, input bit v = 1'b1);
    repeat (n) begin
      L.push_back(v); cp_en.push_back(1'($urandom)); cp_odd.push_back(1'($urandom));
    end
  endtask

  task automatic frame(input logic [7:0] d, input bit fpe, input bit fpo, input bit pinv, input bit stp, input bit scr);
    for (int i = 0; i < OS * (10 + int'(fpe)); i++) begin
      int k;
      bit v;
      k = i / OS;
      v = (k == 0) ? 1'b0 : (k <= DW) ? d[k-1] : (fpe && k == DW + 1) ? (^d ^ fpo ^ pinv) : stp;
      L.push_back(v);
      cp_en.push_back((scr && i > 0) ? 1'($urandom) : fpe);
      cp_odd.push_back((scr && i > 0) ? 1'($urandom) : fpo);
    end
  endtask

  function automatic int mj(input int s, input int k);
    int c;
    c = s + k * OS + MID;
    if (c + 1 >= L.size()) return -1;
    return (int'(L[c-1]) + int'(L[c]) + int'(L[c+1]) >= 2) ? 1 : 0;
  endfunction

  task automatic model();
    int n, t, j;
    bit f, p;
    n = L.size();
    t = 0;
    exp_en.delete(); exp_dn.delete();
    eb = new[n]; ef = new[n]; ep = new[n];
    foreach (eb[i]) eb[i] = 1'b0;
    while (t < n) begin
      int s, e, b, x, tv;
      bit pl, ol, tr;
      if (L[t]) begin
        t++;
        continue;
      end
      s = t; pl = cp_en[s]; ol = cp_odd[s]; e = n; tr = 1'b0; x = 0;
      b = mj(s, 0);
      if (b == 1) e = s + MID + 1;
      else if (b == 0) begin
        for (int k = 1; k <= DW && !tr; k++) begin
          b = mj(s, k);
          if (b < 0) tr = 1'b1;
          else begin
            exp_en.push_back('{s + k * OS + MID + 1, k - 1, b});
            x ^= b;
          end
        end
        if (!tr && pl) begin
          b = mj(s, DW + 1);
          if (b < 0) tr = 1'b1;
          else x = x ^ b ^ int'(ol);
        end
        if (!tr) begin
          b = mj(s, DW + 1 + int'(pl));
          if (b >= 0) begin
            tv = s + (DW + 1 + int'(pl)) * OS + MID + 1;
            exp_dn.push_back('{tv, 1 - b, pl ? x : 0});
            if (b == 1) e = tv;
            else begin
              e = tv + 1;
              while (e < n && !L[e]) e++;
            end
          end
        end
      end
      for (int i = s; i < e && i < n; i++) eb[i] = 1'b1;
      t = e + 1;
    end
    j = 0; f = 1'b0; p = 1'b0;
    for (int i = 0; i < n; i++) begin
      while (j < exp_dn.size() && exp_dn[j].t <= i) begin
        f = exp_dn[j].a[0]; p = exp_dn[j].b[0]; j++;
      end
      ef[i] = f; ep[i] = p;
    end
  endtask

  task automatic tick(input bit v, input bit e, input bit o, input int id);
    @(negedge UCLK);
    rx_in = v; parity_en = e; parity_odd = o; tick_id = id; os_tick = 1'b1;
    @(negedge UCLK);
    os_tick = 1'b0;
    @(negedge UCLK);
  endtask

  task automatic play();
    got_en.delete(); got_dn.delete(); gb.delete(); gf.delete(); gp.delete();
    foreach (L[t]) begin
      @(negedge UCLK);
      rx_in = L[t]; parity_en = cp_en[t]; parity_odd = cp_odd[t]; tick_id = t; os_tick = 1'b1;
      @(negedge UCLK);
      os_tick = 1'b0;
      gb.push_back(busy); gf.push_back(fe); gp.push_back(pe);
      @(negedge UCLK);
    end
    @(negedge UCLK);
    rx_in = 1'b1;
  endtask

  task automatic compare(input string nm);
    int nb, nf, np;
    model();
    chk({nm, "_n_en"}, got_en.size(), exp_en.size());
    for (int i = 0; i < got_en.size() && i < exp_en.size(); i++)
      chk($sformatf("%s_en%0d", nm, i), got_en[i].t * 16 + got_en[i].a * 2 + got_en[i].b,
          exp_en[i].t * 16 + exp_en[i].a * 2 + exp_en[i].b);
    chk({nm, "_n_done"}, got_dn.size(), exp_dn.size());
    for (int i = 0; i < got_dn.size() && i < exp_dn.size(); i++)
      chk($sformatf("%s_done%0d", nm, i), got_dn[i].t * 4 + got_dn[i].a * 2 + got_dn[i].b,
          exp_dn[i].t * 4 + exp_dn[i].a * 2 + exp_dn[i].b);
    nb = 0; nf = 0; np = 0;
    for (int i = 0; i < L.size(); i++) begin
      if (gb[i] !== eb[i]) nb++;
      if (gf[i] !== ef[i]) nf++;
      if (gp[i] !== ep[i]) np++;
    end
    chk({nm, "_busy_trace_errs"}, nb, 0);
    chk({nm, "_fe_trace_errs"}, nf, 0);
    chk({nm, "_pe_trace_errs"}, np, 0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge UCLK);
    reset = 1'b0;
    #1;
    chk({nm, "_rst_outputs"}, {de, di, sb, busy, done, fe, pe}, 0);
    @(negedge UCLK);
    reset = 1'b1;
  endtask

  task automatic run_seg(input string nm);
    do_reset(nm);
    play();
    compare(nm);
  endtask

  function automatic int byte_of(input int first);
    int r;
    r = 0;
    for (int i = 0; i < DW; i++)
      if (first + i < got_en.size()) r |= got_en[first + i].b << got_en[first + i].a;
      else r = -1;
    return r;
  endfunction

  function automatic int done_bit(input int i, input bit want_pe);
    if (i >= got_dn.size()) return -1;
    return want_pe ? got_dn[i].b : got_dn[i].a;
  endfunction

  initial begin
    #1;
    chk("por_outputs", {de, di, sb, busy, done, fe, pe}, 0);

    clear_stim(); idle(10); frame(8'hA5, 0, 0, 0, 1, 0); idle(20);
    run_seg("t1_a5");
    chk("t1_data", byte_of(0), 8'hA5);
    chk("t1_latency", got_dn.size() > 0 ? got_dn[0].t - 10 : -1, (DW + 1) * OS + MID + 1);
    chk("t1_fe", done_bit(0, 0), 0);
    chk("t1_pe", done_bit(0, 1), 0);

    clear_stim(); idle(5); idle(4, 1'b0); idle(40);
    run_seg("t2_glitch");
    chk("t2_busy_low_end", gb[gb.size() - 1], 0);

    clear_stim(); idle(5);
    frame(8'h03, 1, 0, 0, 1, 1); idle(8);
    frame(8'h03, 1, 0, 1, 1, 1); idle(8);
    frame(8'h03, 1, 1, 0, 1, 1); idle(10);
    run_seg("t3_parity");
    chk("t3_even_ok", done_bit(0, 1), 0);
    chk("t3_even_bad", done_bit(1, 1), 1);
    chk("t3_odd_ok", done_bit(2, 1), 0);

    clear_stim(); idle(5); frame(8'h5A, 0, 0, 0, 0, 0); idle(40, 1'b0); idle(20);
    frame(8'h5A, 0, 0, 0, 1, 0); idle(20);
    run_seg("t4_stop");
    chk("t4_fe", done_bit(0, 0), 1);
    chk("t4_n_frames", got_dn.size(), 2);
    chk("t4_next_data", byte_of(8), 8'h5A);
    chk("t4_next_fe", done_bit(1, 0), 0);

    clear_stim(); idle(6); frame(8'hA5, 0, 0, 0, 1, 0);
    L[6 + 4 * OS + MID] = ~L[6 + 4 * OS + MID];
    idle(10); frame(8'h11, 0, 0, 0, 1, 0); frame(8'h22, 0, 0, 0, 1, 0); idle(20);
    run_seg("t5_noise_b2b");
    chk("t5_noise_data", byte_of(0), 8'hA5);
    chk("t5_b2b_first", byte_of(8), 8'h11);
    chk("t5_b2b_second", byte_of(16), 8'h22);
    chk("t5_n_done", got_dn.size(), 3);

    clear_stim(); idle(5); frame(8'hA5, 0, 0, 0, 1, 0);
    while (L.size() > 5 + 5 * OS + 4) begin
      void'(L.pop_back()); void'(cp_en.pop_back()); void'(cp_odd.pop_back());
    end
    run_seg("t6_pre_rst");
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_rst_outputs", {de, di, sb, busy, done, fe, pe}, 0);
    got_en.delete(); got_dn.delete();
    for (int i = 0; i < 40; i++) tick(1'(i % 3 == 0), 0, 0, -2);
    chk("t6_no_pulse_in_rst", got_en.size() + got_dn.size(), 0);
    @(negedge UCLK);
    reset = 1'b1;
    clear_stim(); idle(4); frame(8'hFF, 0, 0, 0, 1, 0); idle(20);
    got_en.delete(); got_dn.delete();
    play();
    compare("t6_post_rst");
    chk("t6_ff_data", byte_of(0), 8'hFF);

    for (int r = 0; r < 18; r++) begin
      int nf, nflip, base;
      clear_stim();
      idle($urandom_range(15, 2));
      base = L.size();
      nf = $urandom_range(3, 1);
      for (int f = 0; f < nf; f++) begin
        frame(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3, 0) == 0,
              $urandom_range(7, 0) != 0, 1'b1);
        idle($urandom_range(12, 0));
        if ($urandom_range(4, 0) == 0) begin
          idle($urandom_range(6, 1), 1'b0);
          idle(20);
        end
      end
      nflip = $urandom_range(2, 0);
      for (int k = 0; k < nflip; k++) begin
        int p;
        p = $urandom_range(L.size() - 1, base);
        L[p] = ~L[p];
      end
      idle(30);
      run_seg($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
